ddr3_lane_dly_ctrl: RTL and testbench
=====================================

// Module: ddr3_lane_dly_ctrl
// PURPOSE
//  Fabric-side initiator for the DDR3 lane-controller delay-line interface (DELAY_LINE_SEL/LOAD/DIRECTION/MOVE).
//  Turns LOAD / relative-step / absolute-set commands from read/write leveling into timed MOVE pulse trains.
//  Tracks the current RX DQS and TX DQS tap values and aborts on the lane's out-of-range flags.
//  One instance per lane, on FAB_CLK.
// PARAMETERS
//  TAP_W        8    width of tap counters and CMD_VAL
//  MAX_TAP      127  highest legal tap; any target above it is rejected
//  RX_LOAD_VAL  1    RX tap value after reset/LOAD (matches the lane RX_DQS_DELAY_VAL)
//  TX_LOAD_VAL  1    TX tap value after reset/LOAD (matches the lane TX_DQS_DELAY_VAL)
//  SETUP_CYC    1    cycles SEL/DIRECTION are stable before the first MOVE (>=1)
//  MOVE_GAP     4    MOVE-low settle cycles after each MOVE pulse (>=1)
// PORTS
//  FAB_CLK                     in   1      fabric clock
//  RESET                       in   1      asynchronous reset, active-high
//  CMD_VALID                   in   1      command request
//  CMD_READY                   out  1      controller idle; command accepted on VALID&READY
//  CMD_SEL                     in   1      0 = RX DQS line, 1 = TX DQS line
//  CMD_OP                      in   2      00 LOAD, 01 STEP_INC, 10 STEP_DEC, 11 SET (absolute)
//  CMD_VAL                     in   TAP_W  step count (STEP) or target tap (SET); ignored for LOAD
//  DONE                        out  1      one-cycle completion pulse
//  ERR                         out  1      last command failed; valid with DONE, held until next accept
//  RX_TAP / TX_TAP             out  TAP_W  current tap of each line
//  DELAY_LINE_SEL              out  1      to lane controller; 1 = TX line
//  DELAY_LINE_LOAD             out  1      to lane controller; one-cycle load pulse
//  DELAY_LINE_DIRECTION        out  1      to lane controller; 1 = increment
//  DELAY_LINE_MOVE             out  1      to lane controller; one-cycle step pulse
//  RX_DELAY_LINE_OUT_OF_RANGE  in   1      from lane controller
//  TX_DELAY_LINE_OUT_OF_RANGE  in   1      from lane controller
// BEHAVIOUR
//  Reset values: state IDLE; CMD_READY=1; DONE, ERR, SEL, LOAD, DIRECTION, MOVE = 0; RX_TAP=RX_LOAD_VAL; TX_TAP=TX_LOAD_VAL.
//  Reset asserted mid-operation: MOVE/LOAD drop immediately and the taps return to their LOAD_VALs.
//    The lane controller resets its delay lines on the same RESET, so the two stay consistent.
//  FSM: IDLE -> (LOAD | CHECK); CHECK -> (SETUP | DONE); SETUP -> MOVE; MOVE -> GAP; GAP -> (MOVE | DONE); DONE -> IDLE.
//  IDLE: CMD_READY=1 only here. On accept, latch sel/op/val, clear ERR, drive SEL=CMD_SEL.
//  LOAD: LOAD=1 for exactly one cycle; the selected tap is set to its LOAD_VAL; next state DONE.
//    DONE asserts 2 cycles after the accept cycle.
//  CHECK, combinational in the accept cycle (it adds no cycle):
//    SET: target>MAX_TAP -> ERR.
//      target==tap -> DONE with no pulses.
//      otherwise DIRECTION=(target>tap) and count=|target-tap|.
//    STEP_INC: tap+val>MAX_TAP, evaluated in TAP_W+1 bits -> ERR.
//    STEP_DEC: val>tap -> ERR.
//    STEP with val==0 -> DONE with no pulses.
//    Any ERR result -> DONE next cycle with ERR=1; MOVE and the taps are untouched.
//  SETUP: SEL and DIRECTION held for SETUP_CYC cycles. Both stay stable through the whole command and keep their values afterwards.
//  MOVE: MOVE=1 for one cycle; the selected tap is updated by +/-1 on that same clock edge; count decrements.
//  GAP: MOVE=0 for MOVE_GAP cycles. After the last GAP cycle: count>0 -> MOVE, count==0 -> DONE.
//  Out-of-range: the flag for the selected line is sampled on every GAP cycle.
//    When it is seen high: abort, go to DONE next cycle with ERR=1.
//    The tap then reflects every pulse actually issued. The flag for the unselected line is ignored.
//  Latency for N>0 pulses: DONE asserts exactly 1+SETUP_CYC+N*(1+MOVE_GAP) cycles after the accept cycle.
//  DONE: one-cycle pulse. CMD_READY returns to 1 in the following cycle.
//    CMD_VALID during a busy command is not accepted and is held by the requester.
//  MOVE and LOAD are never high together, and never high in consecutive cycles.
// STRUCTURE
//  Package ddr3_lane_dly_pkg holds:
//    op encodings (OP_LOAD, OP_INC, OP_DEC, OP_SET);
//    the state enum;
//    the SEL_RX/SEL_TX constants.
//  Sub-module ddr3_dly_step_timer: loadable down-counter producing the SETUP/GAP expiry strobes.
//  Top level: FSM, pulse counter, tap registers.
// TESTING
//  1. After reset: RX_TAP=TX_TAP=1, all strobes 0, CMD_READY=1.
//  2. SET RX to 4 (defaults) -> SEL=0, DIR=1, 3 MOVE pulses spaced 5 cycles apart, DONE at accept+17, RX_TAP=4, ERR=0.
//  3. STEP_DEC TX by 2 from 1 -> no MOVE, DONE at accept+1, ERR=1, TX_TAP=1.
//     Then SET TX to 200 -> ERR=1, no pulses.
//  4. STEP_INC RX by 10 with RX_OUT_OF_RANGE forced high after the 3rd pulse -> exactly 3 pulses, DONE+ERR, RX_TAP=7.
//     A TX flag raised in the same run is ignored.
//  5. LOAD TX after TX_TAP=9 -> one-cycle LOAD with SEL=1, DONE at accept+2, TX_TAP=1, RX_TAP unchanged.
//  6. RESET asserted in the middle of a 5-pulse SET -> MOVE falls within that cycle, taps=1, CMD_READY=1.
//     A fresh command then completes normally.

Source files
------------

// File: rtl/ddr3_lane_dly_pkg.sv
// Shared encodings for the DDR3 lane delay-line controller.
package ddr3_lane_dly_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SET  = 2'b11;

  localparam logic SEL_RX = 1'b0;
  localparam logic SEL_TX = 1'b1;

  // Range/step checking is combinational in the accept cycle, so it has no state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_MOVE,
    ST_GAP,
    ST_DONE
  } dly_state_t;

endpackage

// File: rtl/ddr3_dly_step_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ddr3_dly_step_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ddr3_lane_dly_ctrl.sv
// Per-lane delay-line initiator: turns LOAD/STEP/SET commands into timed
// MOVE pulse trains and tracks the RX/TX DQS tap values.
module ddr3_lane_dly_ctrl
  import ddr3_lane_dly_pkg::*;
#(
  parameter int TAP_W       = 8,
  parameter int MAX_TAP     = 127,
  parameter int RX_LOAD_VAL = 1,
  parameter int TX_LOAD_VAL = 1,
  parameter int SETUP_CYC   = 1,
  parameter int MOVE_GAP    = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_SEL,
  input  logic [1:0]       CMD_OP,
  input  logic [TAP_W-1:0] CMD_VAL,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] RX_TAP,
  output logic [TAP_W-1:0] TX_TAP,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

  localparam int TMR_MAX = (SETUP_CYC > MOVE_GAP) ? SETUP_CYC : MOVE_GAP;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAP);
  localparam logic [TAP_W:0]   MAX_TAP_X = (TAP_W+1)'(MAX_TAP);
  localparam logic [TAP_W-1:0] RX_LD_V   = TAP_W'(RX_LOAD_VAL);
  localparam logic [TAP_W-1:0] TX_LD_V   = TAP_W'(TX_LOAD_VAL);

  dly_state_t       state;
  logic [TAP_W-1:0] pulse_cnt;
  logic [TAP_W-1:0] cur_tap;
  logic [TAP_W:0]   sum_ext;
  logic             chk_err;
  logic             chk_zero;
  logic             chk_dir;
  logic [TAP_W-1:0] chk_cnt;
  logic             accept;
  logic             go_setup;
  logic             line_oor;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_expired;

  assign accept   = CMD_VALID && CMD_READY;
  assign go_setup = (CMD_OP != OP_LOAD) && !chk_err && !chk_zero;
  assign line_oor = (DELAY_LINE_SEL == SEL_TX) ? TX_DELAY_LINE_OUT_OF_RANGE
                                               : RX_DELAY_LINE_OUT_OF_RANGE;
  assign tmr_load     = (accept && go_setup) || (state == ST_MOVE);
  assign tmr_load_val = (state == ST_MOVE) ? GAP_LD : SETUP_LD;

  // Range check, direction and pulse count of the command being offered.
  always_comb begin
    cur_tap  = (CMD_SEL == SEL_TX) ? TX_TAP : RX_TAP;
    sum_ext  = {1'b0, cur_tap} + {1'b0, CMD_VAL};
    chk_err  = 1'b0;
    chk_zero = 1'b0;
    chk_dir  = 1'b0;
    chk_cnt  = '0;
    case (CMD_OP)
      OP_SET: begin
        if (CMD_VAL > MAX_TAP_V) begin
          chk_err = 1'b1;
        end else if (CMD_VAL == cur_tap) begin
          chk_zero = 1'b1;
        end else begin
          chk_dir = (CMD_VAL > cur_tap);
          chk_cnt = chk_dir ? (CMD_VAL - cur_tap) : (cur_tap - CMD_VAL);
        end
      end
      OP_INC: begin
        if (sum_ext > MAX_TAP_X) begin
          chk_err = 1'b1;
        end else if (CMD_VAL == '0) begin
          chk_zero = 1'b1;
        end else begin
          chk_dir = 1'b1;
          chk_cnt = CMD_VAL;
        end
      end
      OP_DEC: begin
        if (CMD_VAL > cur_tap) begin
          chk_err = 1'b1;
        end else if (CMD_VAL == '0) begin
          chk_zero = 1'b1;
        end else begin
          chk_cnt = CMD_VAL;
        end
      end
      default: ;
    endcase
  end

  ddr3_dly_step_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (FAB_CLK),
    .rst      (RESET),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  // Command sequencer with registered handshake and delay-line strobes.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state                <= ST_IDLE;
      CMD_READY            <= 1'b1;
      DONE                 <= 1'b0;
      ERR                  <= 1'b0;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            CMD_READY      <= 1'b0;
            ERR            <= 1'b0;
            DELAY_LINE_SEL <= CMD_SEL;
            if (CMD_OP == OP_LOAD) begin
              DELAY_LINE_LOAD <= 1'b1;
              state           <= ST_LOAD;
            end else if (chk_err) begin
              DONE  <= 1'b1;
              ERR   <= 1'b1;
              state <= ST_DONE;
            end else if (chk_zero) begin
              DONE  <= 1'b1;
              state <= ST_DONE;
            end else begin
              DELAY_LINE_DIRECTION <= chk_dir;
              state                <= ST_SETUP;
            end
          end
        end
        ST_LOAD: begin
          DELAY_LINE_LOAD <= 1'b0;
          DONE            <= 1'b1;
          state           <= ST_DONE;
        end
        ST_SETUP: begin
          if (tmr_expired) begin
            DELAY_LINE_MOVE <= 1'b1;
            state           <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          DELAY_LINE_MOVE <= 1'b0;
          state           <= ST_GAP;
        end
        ST_GAP: begin
          if (line_oor) begin
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            state <= ST_DONE;
          end else if (tmr_expired) begin
            if (pulse_cnt != '0) begin
              DELAY_LINE_MOVE <= 1'b1;
              state           <= ST_MOVE;
            end else begin
              DONE  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          DONE      <= 1'b0;
          CMD_READY <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Remaining MOVE pulses of the current command.
  always_ff @(posedge FAB_CLK) begin
    if (accept) begin
      pulse_cnt <= chk_cnt;
    end else if (state == ST_MOVE) begin
      pulse_cnt <= pulse_cnt - 1'b1;
    end
  end

  // Tap shadows follow every LOAD and MOVE actually issued to the lane.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      RX_TAP <= RX_LD_V;
      TX_TAP <= TX_LD_V;
    end else if (state == ST_LOAD) begin
      if (DELAY_LINE_SEL == SEL_TX) TX_TAP <= TX_LD_V;
      else                          RX_TAP <= RX_LD_V;
    end else if (state == ST_MOVE) begin
      if (DELAY_LINE_SEL == SEL_TX)
        TX_TAP <= DELAY_LINE_DIRECTION ? (TX_TAP + 1'b1) : (TX_TAP - 1'b1);
      else
        RX_TAP <= DELAY_LINE_DIRECTION ? (RX_TAP + 1'b1) : (RX_TAP - 1'b1);
    end
  end

endmodule

// File: tb/tb_ddr3_lane_dly_ctrl.sv
// Randomized bench for ddr3_lane_dly_ctrl against a command-level model.
module tb_ddr3_lane_dly_ctrl;

  localparam int SETUP = 1;
  localparam int GAP   = 4;
  localparam int MAXT  = 127;
  localparam int LDV   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_sel;
  logic [1:0] cmd_op;
  logic [7:0] cmd_val;
  logic       done;
  logic       err;
  logic [7:0] rx_tap;
  logic [7:0] tx_tap;
  logic       dl_sel;
  logic       dl_load;
  logic       dl_dir;
  logic       dl_move;
  logic       rx_oor;
  logic       tx_oor;

  int n_checks = 0;
  int n_errors = 0;
  int m_rx = LDV;
  int m_tx = LDV;

  always #5 clk = ~clk;

  ddr3_lane_dly_ctrl #(
    .TAP_W(8), .MAX_TAP(MAXT), .RX_LOAD_VAL(LDV), .TX_LOAD_VAL(LDV),
    .SETUP_CYC(SETUP), .MOVE_GAP(GAP)
  ) dut (
    .FAB_CLK                    (clk),
    .RESET                      (rst),
    .CMD_VALID                  (cmd_valid),
    .CMD_READY                  (cmd_ready),
    .CMD_SEL                    (cmd_sel),
    .CMD_OP                     (cmd_op),
    .CMD_VAL                    (cmd_val),
    .DONE                       (done),
    .ERR                        (err),
    .RX_TAP                     (rx_tap),
    .TX_TAP                     (tx_tap),
    .DELAY_LINE_SEL             (dl_sel),
    .DELAY_LINE_LOAD            (dl_load),
    .DELAY_LINE_DIRECTION       (dl_dir),
    .DELAY_LINE_MOVE            (dl_move),
    .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor),
    .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command and score it. oor_req: 0 none, >0 raise the selected
  // line's flag after that many pulses, -1 pick randomly.
  task automatic run_cmd(input logic sel, input logic [1:0] op, input int val,
                         input int oor_req, input bit other_oor);
    int tap, n, m, lat, exp_moves, exp_loads, new_tap, budget;
    int done_k, moves, loads, bad_pos, bad_sel, busy_bad, viol, wait_cnt;
    bit e, dir, prev;
    tap = sel ? m_tx : m_rx;
    n = 0; e = 0; dir = 0; exp_loads = 0; exp_moves = 0; m = 0;
    case (op)
      2'b00: exp_loads = 1;
      2'b11: if (val > MAXT) e = 1; else begin
               dir = (val > tap); n = dir ? val - tap : tap - val; end
      2'b01: if (tap + val > MAXT) e = 1; else begin n = val; dir = 1; end
      default: if (val > tap) e = 1; else n = val;
    endcase
    if (oor_req < 0) m = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
    else m = oor_req;
    if (e || n == 0 || m > n) m = 0;
    if (op == 2'b00)  lat = 2;
    else if (e || n == 0) lat = 1;
    else if (m > 0) begin lat = 3 + SETUP + (m - 1) * (1 + GAP); exp_moves = m; e = 1; end
    else begin lat = 1 + SETUP + n * (1 + GAP); exp_moves = n; end
    new_tap = (op == 2'b00) ? LDV : (dir ? tap + exp_moves : tap - exp_moves);

    wait_cnt = 0;
    @(negedge clk);
    while (!cmd_ready && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
    if (!cmd_ready) begin
      check_val("ready_timeout", 0, 1);
      return;
    end
    cmd_valid = 1'b1; cmd_sel = sel; cmd_op = op; cmd_val = 8'(val);
    if (other_oor) begin if (sel) rx_oor = 1'b1; else tx_oor = 1'b1; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_val = 8'($urandom_range(0, 255));
    done_k = 0; moves = 0; loads = 0; bad_pos = 0; bad_sel = 0; busy_bad = 0;
    viol = 0; prev = 0;
    budget = lat + 20;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (dl_move && dl_load) viol++;
      if ((dl_move || dl_load) && prev) viol++;
      prev = dl_move || dl_load;
      if (cmd_ready) busy_bad++;
      if (dl_move) begin
        if (k != 1 + SETUP + moves * (1 + GAP)) bad_pos++;
        if (dl_sel !== sel || dl_dir !== dir) bad_sel++;
        moves++;
        if (moves == m) begin if (sel) tx_oor = 1'b1; else rx_oor = 1'b1; end
      end
      if (dl_load) begin
        if (dl_sel !== sel) bad_sel++;
        loads++;
      end
      if (done) begin done_k = k; break; end
    end
    if (sel) m_tx = new_tap; else m_rx = new_tap;
    check_val("done_latency", done_k, lat);
    check_val("move_count", moves, exp_moves);
    check_val("load_count", loads, exp_loads);
    check_val("err_at_done", int'(err), int'(e));
    check_val("rx_tap", int'(rx_tap), m_rx);
    check_val("tx_tap", int'(tx_tap), m_tx);
    check_val("move_spacing", bad_pos, 0);
    check_val("sel_dir_stable", bad_sel, 0);
    check_val("strobe_overlap", viol, 0);
    check_val("ready_while_busy", busy_bad, 0);
    @(negedge clk);
    check_val("done_one_cycle", int'(done), 0);
    check_val("ready_after_done", int'(cmd_ready), 1);
    check_val("err_held", int'(err), int'(e));
    rx_oor = 1'b0; tx_oor = 1'b0;
  endtask

  initial begin
    int mv;
    logic [1:0] rop;
    int rval, rtap;
    logic rsel;
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_op = 2'b00; cmd_val = '0;
    rx_oor = 1'b0; tx_oor = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rx_tap", int'(rx_tap), 1);
    check_val("rst_tx_tap", int'(tx_tap), 1);
    check_val("rst_ready", int'(cmd_ready), 1);
    check_val("rst_strobes", int'({done, err, dl_sel, dl_load, dl_dir, dl_move}), 0);
    rst = 1'b0;

    run_cmd(1'b0, 2'b11, 4, 0, 0);    // SET RX 4: 3 pulses
    run_cmd(1'b1, 2'b10, 2, 0, 0);    // DEC TX by 2 from 1: error
    run_cmd(1'b1, 2'b11, 200, 0, 0);  // SET TX beyond range: error
    run_cmd(1'b0, 2'b01, 10, 3, 1);   // INC RX 10, abort after 3, TX flag ignored
    run_cmd(1'b1, 2'b11, 9, 0, 0);    // TX to 9
    run_cmd(1'b1, 2'b00, 0, 0, 0);    // LOAD TX
    run_cmd(1'b0, 2'b10, 0, 0, 0);    // zero-length step
    run_cmd(1'b1, 2'b01, MAXT - 1, 0, 0); // INC to exactly MAX_TAP
    run_cmd(1'b1, 2'b01, 1, 0, 0);    // one past MAX_TAP: error
    run_cmd(1'b1, 2'b00, 0, 0, 0);

    // Reset in the middle of a 5-pulse SET
    m_rx = int'(rx_tap);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_op = 2'b11; cmd_val = 8'(m_rx + 5);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    mv = 0;
    for (int k = 0; k < 40 && mv < 2; k++) begin
      @(negedge clk);
      if (dl_move) mv++;
    end
    check_val("mid_reset_saw_moves", mv, 2);
    rst = 1'b1;
    #1;
    check_val("mid_reset_move", int'(dl_move), 0);
    check_val("mid_reset_rx", int'(rx_tap), 1);
    check_val("mid_reset_tx", int'(tx_tap), 1);
    check_val("mid_reset_ready", int'(cmd_ready), 1);
    m_rx = LDV; m_tx = LDV;
    @(negedge clk);
    rst = 1'b0;
    run_cmd(1'b0, 2'b11, 6, 0, 0);

    // Randomized command stream
    for (int i = 0; i < 40; i++) begin
      rsel = 1'($urandom_range(0, 1));
      rop  = 2'($urandom_range(0, 3));
      rtap = rsel ? m_tx : m_rx;
      case (rop)
        2'b11:   rval = ($urandom_range(0, 9) == 0) ? $urandom_range(128, 255) : $urandom_range(0, 60);
        2'b01:   rval = $urandom_range(0, 20);
        2'b10:   rval = $urandom_range(0, rtap + 3);
        default: rval = $urandom_range(0, 255);
      endcase
      run_cmd(rsel, rop, rval, -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
